// File: rtl/adc_frame_packer.sv
// adc_frame_packer
//
// Collects 16-word ADC frames from an ID-tagged word stream into a two-slot
// frame buffer, then emits each frame as a header {HDR_TAG, base_id} followed
// by the 16 data words over a valid/ready output.
//
// Optional feature: define PACKER_CHECKSUM_EN to append a modulo-2^16 sum of
// the 16 data words after data word 15. The checksum word then carries
// out_eof, giving 18 words per frame instead of 17.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   fiber_in   in   16-bit data word, aligned with id_in
//   id_in      in   8-bit per-word ADC ID; IDLE_ID marks a non-data word
//   out_ready  in   downstream accepts out_data when out_valid is high
//   out_data   out  packed frame word
//   out_valid  out  out_data is valid
//   out_sof    out  header word of a frame
//   out_eof    out  last word of a frame
//   frame_cnt  out  frames emitted (wraps)
//   drop_cnt   out  frames discarded (saturates at 8'hFF)
//   seq_err    out  sticky ID sequence violation flag
module adc_frame_packer #(
    parameter logic [7:0] IDLE_ID = 8'hB3,
    parameter logic [7:0] HDR_TAG = 8'hC5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] fiber_in,
    input  logic [7:0]  id_in,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        out_valid,
    output logic        out_sof,
    output logic        out_eof,
    output logic [15:0] frame_cnt,
    output logic [7:0]  drop_cnt,
    output logic        seq_err
);

    typedef enum logic {CapIdle, CapCapt} cap_state_t;
`ifdef PACKER_CHECKSUM_EN
    typedef enum logic [1:0] {OutIdle, OutHdr, OutData, OutCsum} out_state_t;
`else
    typedef enum logic [1:0] {OutIdle, OutHdr, OutData} out_state_t;
`endif

    // Frame buffer
    logic [15:0] r_mem  [0:1][0:15];
    logic [7:0]  r_base [0:1];
    logic [1:0]  r_full;
    logic        r_wr_ptr;
    logic        r_rd_ptr;

    // Capture side
    cap_state_t  r_cap_state;
    logic [3:0]  r_cap_idx;
    logic [7:0]  r_expected;
    logic        r_cap_drop;   // current frame started with no free slot
    logic [7:0]  r_drop_cnt;
    logic        r_seq_err;

    // Output side
    out_state_t  r_out_state;
    logic [3:0]  r_oidx;
    logic [15:0] r_out_data;
    logic        r_out_valid;
    logic        r_out_sof;
    logic        r_out_eof;
    logic [15:0] r_frame_cnt;
`ifdef PACKER_CHECKSUM_EN
    logic [15:0] r_sum;
`endif

    logic w_is_data;
    logic w_in_seq;
    logic w_commit;
    logic w_drop_evt;
    logic w_free;
    logic w_nxt_slot;

    assign w_is_data  = (id_in != IDLE_ID);
    assign w_in_seq   = (id_in == r_expected);
    assign w_commit   = (r_cap_state == CapCapt) && w_is_data && w_in_seq &&
                        (r_cap_idx == 4'd15) && !r_cap_drop;
    // Abort (short frame or bad ID) or completion of a frame with no slot.
    assign w_drop_evt = (r_cap_state == CapCapt) &&
                        (!w_is_data || !w_in_seq || ((r_cap_idx == 4'd15) && r_cap_drop));
    assign w_nxt_slot = ~r_rd_ptr;
`ifdef PACKER_CHECKSUM_EN
    assign w_free     = (r_out_state == OutCsum) && out_ready;
`else
    assign w_free     = (r_out_state == OutData) && out_ready && (r_oidx == 4'd15);
`endif

    // Capture FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cap_state <= CapIdle;
            r_cap_idx   <= 4'd0;
            r_expected  <= 8'd0;
            r_cap_drop  <= 1'b0;
            r_wr_ptr    <= 1'b0;
            r_drop_cnt  <= 8'd0;
            r_seq_err   <= 1'b0;
        end else begin
            if (w_drop_evt && (r_drop_cnt != 8'hFF)) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
            unique case (r_cap_state)
                CapIdle: begin
                    if (w_is_data) begin
                        if (!r_full[r_wr_ptr]) begin
                            r_mem[r_wr_ptr][0] <= fiber_in;
                            r_base[r_wr_ptr]   <= id_in;
                        end
                        r_cap_drop  <= r_full[r_wr_ptr];
                        r_cap_idx   <= 4'd1;
                        r_expected  <= id_in + 8'd1;
                        r_cap_state <= CapCapt;
                    end
                end
                CapCapt: begin
                    if (!w_is_data) begin
                        r_cap_state <= CapIdle;
                    end else if (!w_in_seq) begin
                        // Offending word is discarded, not used to start a frame.
                        r_seq_err   <= 1'b1;
                        r_cap_state <= CapIdle;
                    end else begin
                        if (!r_cap_drop) begin
                            r_mem[r_wr_ptr][r_cap_idx] <= fiber_in;
                        end
                        r_cap_idx  <= r_cap_idx + 4'd1;
                        r_expected <= r_expected + 8'd1;
                        if (r_cap_idx == 4'd15) begin
                            r_cap_state <= CapIdle;
                            if (!r_cap_drop) begin
                                r_wr_ptr <= ~r_wr_ptr;
                            end
                        end
                    end
                end
                default: r_cap_state <= CapIdle;
            endcase
        end
    end

    // Slot occupancy; commit and free always target different slots.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_full <= 2'b00;
        end else begin
            if (w_commit) begin
                r_full[r_wr_ptr] <= 1'b1;
            end
            if (w_free) begin
                r_full[r_rd_ptr] <= 1'b0;
            end
        end
    end

    // Output FSM with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_state <= OutIdle;
            r_oidx      <= 4'd0;
            r_out_data  <= 16'h0000;
            r_out_valid <= 1'b0;
            r_out_sof   <= 1'b0;
            r_out_eof   <= 1'b0;
            r_rd_ptr    <= 1'b0;
            r_frame_cnt <= 16'd0;
`ifdef PACKER_CHECKSUM_EN
            r_sum       <= 16'd0;
`endif
        end else if (w_free) begin
            r_rd_ptr    <= w_nxt_slot;
            r_frame_cnt <= r_frame_cnt + 16'd1;
            r_out_eof   <= 1'b0;
            // Chain straight into the next header when the other slot is ready.
            if (r_full[w_nxt_slot]) begin
                r_out_data  <= {HDR_TAG, r_base[w_nxt_slot]};
                r_out_sof   <= 1'b1;
                r_out_state <= OutHdr;
            end else begin
                r_out_valid <= 1'b0;
                r_out_sof   <= 1'b0;
                r_out_state <= OutIdle;
            end
        end else begin
            unique case (r_out_state)
                OutIdle: begin
                    if (r_full[r_rd_ptr]) begin
                        r_out_data  <= {HDR_TAG, r_base[r_rd_ptr]};
                        r_out_valid <= 1'b1;
                        r_out_sof   <= 1'b1;
                        r_out_eof   <= 1'b0;
                        r_out_state <= OutHdr;
                    end
                end
                OutHdr: begin
                    if (out_ready) begin
                        r_out_data  <= r_mem[r_rd_ptr][0];
                        r_out_sof   <= 1'b0;
                        r_oidx      <= 4'd0;
`ifdef PACKER_CHECKSUM_EN
                        r_sum       <= r_mem[r_rd_ptr][0];
`endif
                        r_out_state <= OutData;
                    end
                end
                OutData: begin
                    if (out_ready) begin
`ifdef PACKER_CHECKSUM_EN
                        if (r_oidx == 4'd15) begin
                            r_out_data  <= r_sum;
                            r_out_eof   <= 1'b1;
                            r_out_state <= OutCsum;
                        end else begin
                            r_out_data <= r_mem[r_rd_ptr][r_oidx + 4'd1];
                            r_sum      <= r_sum + r_mem[r_rd_ptr][r_oidx + 4'd1];
                            r_oidx     <= r_oidx + 4'd1;
                        end
`else
                        r_out_data <= r_mem[r_rd_ptr][r_oidx + 4'd1];
                        r_out_eof  <= (r_oidx == 4'd14);
                        r_oidx     <= r_oidx + 4'd1;
`endif
                    end
                end
                default: r_out_state <= OutIdle;
            endcase
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_sof   = r_out_sof;
    assign out_eof   = r_out_eof;
    assign frame_cnt = r_frame_cnt;
    assign drop_cnt  = r_drop_cnt;
    assign seq_err   = r_seq_err;

endmodule
